// File: rtl/interface_dht_param.sv
// Single-wire DHT11/DHT22 receiver: host start pulse, pulse-width bit decoding,
// checksum verification and automatic retry on timeout or checksum failure.
module interface_dht_param #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned START_US_DHT11 = 18000,
    parameter int unsigned START_US_DHT22 = 1000,
    parameter int unsigned BIT_THRESH_US  = 50,
    parameter int unsigned TIMEOUT_US     = 200,
    parameter int unsigned RETRY_GAP_US   = 2000,
    parameter int unsigned MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir_dht,
    input  logic        modo,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        ocupado,
    output logic        pronto,
    output logic [15:0] umidade_out,
    output logic [15:0] temperatura_out,
    output logic        erro_checksum,
    output logic        erro_timeout,
    output logic [1:0]  tentativas
);

    localparam int unsigned CYC_PER_US  = CLK_HZ / 1000000;
    localparam int unsigned START11_CYC = CYC_PER_US * START_US_DHT11;
    localparam int unsigned START22_CYC = CYC_PER_US * START_US_DHT22;
    localparam int unsigned BIT_CYC     = CYC_PER_US * BIT_THRESH_US;
    localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int unsigned RETRY_CYC   = CYC_PER_US * RETRY_GAP_US;

    localparam int unsigned MAX_A   = (START11_CYC > START22_CYC) ? START11_CYC : START22_CYC;
    localparam int unsigned MAX_B   = (RETRY_CYC > TIMEOUT_CYC) ? RETRY_CYC : TIMEOUT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] START11_END = CNT_W'(START11_CYC - 1);
    localparam logic [CNT_W-1:0] START22_END = CNT_W'(START22_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_END   = CNT_W'(RETRY_CYC - 1);
    // Counter reads length-1 on the cycle the falling edge is seen.
    localparam logic [CNT_W-1:0] BIT_ONE_MIN = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [1:0]       MAX_T       = 2'(MAX_TENTATIVAS);

    localparam logic [3:0] INICIAL     = 4'd0;
    localparam logic [3:0] START_LOW   = 4'd1;
    localparam logic [3:0] ESPERA_RESP = 4'd2;
    localparam logic [3:0] RESP_LOW    = 4'd3;
    localparam logic [3:0] RESP_HIGH   = 4'd4;
    localparam logic [3:0] BIT_LOW     = 4'd5;
    localparam logic [3:0] BIT_HIGH    = 4'd6;
    localparam logic [3:0] VERIFICA    = 4'd7;
    localparam logic [3:0] RETRY_GAP   = 4'd8;
    localparam logic [3:0] FIM         = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sync_q;
    logic [39:0]      data_q;
    logic [5:0]       idx_q;
    logic [1:0]       attempt_q;
    logic             modo_q;

    logic             fall, rise, phase_to;
    logic             accept, shift_en, load_out, fail_to, fail_ck;
    logic [CNT_W-1:0] start_end;
    logic [7:0]       checksum;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value.
    assign fall      = sync_q[2] & ~sync_q[1];
    assign rise      = ~sync_q[2] & sync_q[1];
    assign phase_to  = (cnt_q == TIMEOUT_END);
    assign start_end = modo_q ? START22_END : START11_END;
    assign checksum  = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];

    assign dht_oe  = (state_q == START_LOW);
    assign ocupado = (state_q != INICIAL);
    assign pronto  = (state_q == FIM);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        load_out = 1'b0;
        fail_to  = 1'b0;
        fail_ck  = 1'b0;
        case (state_q)
            INICIAL: begin
                if (medir_dht) begin
                    accept  = 1'b1;
                    state_d = START_LOW;
                end
            end
            START_LOW: begin
                if (cnt_q == start_end) state_d = ESPERA_RESP;
            end
            ESPERA_RESP: begin
                if (fall)          state_d = RESP_LOW;
                else if (phase_to) fail_to = 1'b1;
            end
            RESP_LOW: begin
                if (rise)          state_d = RESP_HIGH;
                else if (phase_to) fail_to = 1'b1;
            end
            RESP_HIGH: begin
                if (fall)          state_d = BIT_LOW;
                else if (phase_to) fail_to = 1'b1;
            end
            BIT_LOW: begin
                if (rise)          state_d = BIT_HIGH;
                else if (phase_to) fail_to = 1'b1;
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_en = 1'b1;
                    state_d  = (idx_q == 6'd39) ? VERIFICA : BIT_LOW;
                end else if (phase_to) begin
                    fail_to = 1'b1;
                end
            end
            VERIFICA: begin
                if (checksum == data_q[7:0]) begin
                    load_out = 1'b1;
                    state_d  = FIM;
                end else begin
                    fail_ck = 1'b1;
                end
            end
            RETRY_GAP: begin
                if (cnt_q == RETRY_END) state_d = START_LOW;
            end
            FIM:     state_d = INICIAL;
            default: state_d = INICIAL;
        endcase
        if (fail_to || fail_ck) begin
            state_d = (attempt_q < MAX_T) ? RETRY_GAP : FIM;
        end
    end

    always_comb begin
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= INICIAL;
            cnt_q           <= '0;
            sync_q          <= 3'b111;
            data_q          <= '0;
            idx_q           <= '0;
            attempt_q       <= '0;
            modo_q          <= 1'b0;
            umidade_out     <= '0;
            temperatura_out <= '0;
            erro_checksum   <= 1'b0;
            erro_timeout    <= 1'b0;
            tentativas      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[1:0], dht_in};

            if (accept) begin
                modo_q        <= modo;
                erro_checksum <= 1'b0;
                erro_timeout  <= 1'b0;
                attempt_q     <= 2'd1;
            end

            if (state_q == RESP_HIGH && state_d == BIT_LOW) idx_q <= '0;
            else if (shift_en)                               idx_q <= idx_q + 6'd1;

            if (shift_en) data_q <= {data_q[38:0], (cnt_q >= BIT_ONE_MIN)};

            if (load_out) begin
                umidade_out     <= data_q[39:24];
                temperatura_out <= data_q[23:8];
            end

            if (fail_to || fail_ck) begin
                if (attempt_q < MAX_T) begin
                    attempt_q <= attempt_q + 2'd1;
                end else begin
                    erro_timeout  <= fail_to;
                    erro_checksum <= fail_ck;
                end
            end

            if (state_q == FIM) tentativas <= attempt_q;
        end
    end

endmodule

// File: doc/interface_dht_param.md
Name: interface_dht_param

Overview:
- Parametrised single-wire receiver for DHT11 and DHT22 humidity/temperature sensors, selectable at run time.
- Generates the host start pulse and decodes the 40-bit frame by pulse-width timing.
- Verifies the checksum and retries automatically on failure.
- Sits between the sensor pin (open-drain, via external tristate) and the measurement controller; replaces the fixed DHT11-only interface.

Parameters:
- CLK_HZ, 50000000, clock frequency; all microsecond constants are converted to cycles as CLK_HZ/1000000 * value.
- START_US_DHT11, 18000, host low pulse length in mode 0.
- START_US_DHT22, 1000, host low pulse length in mode 1.
- BIT_THRESH_US, 50, data-high duration at or above which a bit is decoded as 1.
- TIMEOUT_US, 200, maximum duration of any sensor-driven phase.
- RETRY_GAP_US, 2000, idle gap before a retry.
- MAX_TENTATIVAS, 3, total attempts per request (minimum 1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- medir_dht  in  1  start request; sampled only in INICIAL
- modo  in  1  0 = DHT11, 1 = DHT22; latched at request acceptance
- dht_in  in  1  raw sensor line; 2-flop synchronised internally
- dht_oe  out  1  1 = drive line low; 0 = release (pull-up)
- ocupado  out  1  high from request acceptance until return to INICIAL
- pronto  out  1  one-cycle pulse when an attempt sequence ends (success or error)
- umidade_out  out  16  {byte0, byte1} of the last valid frame
- temperatura_out  out  16  {byte2, byte3} of the last valid frame
- erro_checksum  out  1  last request failed; final attempt had a bad checksum
- erro_timeout  out  1  last request failed; final attempt timed out
- tentativas  out  2  attempts used by the last request (1..MAX_TENTATIVAS)

Behaviour:
- Reset values: all outputs 0; state INICIAL; line released.
- Timing counter: one shared counter, cleared on every state change, width enough for max(START_US_DHT11, RETRY_GAP_US) cycles.
- States and transitions:
  - INICIAL: wait for medir_dht=1. On accept: latch modo, clear both erro flags, attempt count = 1, go to START_LOW.
  - START_LOW: dht_oe=1 for START_US(modo) cycles, then go to ESPERA_RESP.
  - ESPERA_RESP: line released. Falling edge on synchronised line -> RESP_LOW. No falling edge within TIMEOUT_US -> timeout.
  - RESP_LOW: rising edge -> RESP_HIGH.
  - RESP_HIGH: falling edge -> BIT_LOW, bit index = 0.
  - BIT_LOW: rising edge -> BIT_HIGH.
  - BIT_HIGH: on falling edge, shift in a 1 if high length >= BIT_THRESH_US cycles, else 0, MSB first. If index = 39 -> VERIFICA; otherwise index+1 and go to BIT_LOW.
  - Any state from RESP_LOW through BIT_HIGH: phase counter reaching TIMEOUT_US -> timeout.
  - VERIFICA: (byte0+byte1+byte2+byte3) mod 256 = byte4 -> load outputs -> FIM. Mismatch -> checksum fail.
  - Failure: if attempt < MAX_TENTATIVAS -> attempt+1, go to RETRY_GAP (line released, RETRY_GAP_US cycles), then START_LOW. Otherwise set the matching erro flag -> FIM.
  - FIM: pronto=1 for one cycle, write tentativas, go to INICIAL.
- The final (40th) bit's falling edge is the sensor's end-of-frame low; no stop-bit check.
- Latency: the 40th bit is decoded on the cycle after its falling edge is seen on the synchronised line; outputs load in VERIFICA; pronto follows in the next cycle.
- umidade_out and temperatura_out change only on checksum success. They hold their previous values on error.
- No data interpretation: DHT11 decimal bytes and the DHT22 sign bit are passed through raw.
- medir_dht while ocupado=1 is ignored; there is no queuing.
- modo changes during a transaction have no effect.
- Reset mid-operation: dht_oe drops to 0 asynchronously, state returns to INICIAL, outputs clear.
- Glitches shorter than the synchroniser are not filtered beyond the 2-flop synchroniser.

Test Plan (CLK_HZ=1000000, so 1 cycle = 1 us; sensor behavioural model on dht_in):
- DHT11 good frame. modo=0, sensor sends 0x37,0x00,0x19,0x05,0x55 (bit-0 high 27 us, bit-1 high 70 us) -> dht_oe high exactly 18000 cycles; umidade_out=0x3700, temperatura_out=0x1905; pronto 1 cycle; tentativas=1; erro flags 0.
- DHT22 mode. modo=1, frame 0x02,0x8C,0x80,0x65,0x73 -> dht_oe high 1000 cycles; umidade_out=0x028C, temperatura_out=0x8065; no error.
- Checksum retry. First frame has checksum 0x54, second frame is correct -> one RETRY_GAP of 2000 cycles; outputs from second frame; tentativas=2; erro_checksum=0.
- Persistent timeout. Sensor silent -> 3 attempts, each ending 200 cycles after release; erro_timeout=1; tentativas=3; prior outputs unchanged; pronto one pulse.
- Timeout mid-frame. Line stuck high after bit 12 -> timeout 200 cycles later, then retry starts.
- Busy and reset. medir_dht pulsed during BIT_LOW is ignored, ocupado stays 1. Reset asserted during START_LOW -> dht_oe=0 the same cycle; all outputs 0; the next medir_dht starts a clean transaction.
